// File: rtl/lcplc_pkg.sv
// Shared types and field layout for the band sequencer and predictor front end.
// The params bundle is {alpha, xmean, xhatmean} with xhatmean in the low bits.
package lcplc_pkg;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_PARAM = 2'd1,
        ST_NTH   = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_DATA_WIDTH     = 16;
    localparam int unsigned DEF_ALPHA_WIDTH    = 10;
    localparam int unsigned DEF_BLOCK_SIZE_LOG = 8;
    localparam int unsigned DEF_BAND_WIDTH     = 8;
    localparam int unsigned BLOCK_SIZE         = 1 << DEF_BLOCK_SIZE_LOG;

    function automatic int unsigned params_width(input int unsigned alpha_w, input int unsigned data_w);
        return alpha_w + 2 * data_w;
    endfunction

    function automatic int unsigned xmean_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned alpha_lsb(input int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/band_block_counter.sv
// Sample/band position tracking for the band sequencer: sample counter, band index,
// last-sample and block-end detection, and the per-block band-count latch.
module band_block_counter
    import lcplc_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE_LOG = DEF_BLOCK_SIZE_LOG,
    parameter int unsigned BAND_WIDTH     = DEF_BAND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hs,
    input  logic [BAND_WIDTH-1:0] cfg_num_bands,
    output logic                  last_c,
    output logic                  block_end_c,
    output logic [BAND_WIDTH-1:0] band_index,
    output logic                  block_done
);

    localparam int unsigned CNT_W = BLOCK_SIZE_LOG + 1;
    localparam int unsigned BLK   = 1 << BLOCK_SIZE_LOG;

    logic [CNT_W-1:0]      sample_cnt;
    logic [BAND_WIDTH-1:0] num_bands_q;
    logic [BAND_WIDTH-1:0] cfg_eff;
    logic                  cfg_loaded_q;

    // A zero band count still carries the band-0 samples.
    assign cfg_eff     = (cfg_num_bands == '0) ? BAND_WIDTH'(1) : cfg_num_bands;
    assign last_c      = (sample_cnt == CNT_W'(BLK - 1));
    assign block_end_c = last_c && (band_index == num_bands_q - BAND_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt   <= '0;
            band_index   <= '0;
            num_bands_q  <= BAND_WIDTH'(1);
            cfg_loaded_q <= 1'b0;
            block_done   <= 1'b0;
        end else begin
            block_done   <= hs && block_end_c;
            cfg_loaded_q <= 1'b1;
            // Band count is only ever taken at a block boundary (or right after reset).
            if (!cfg_loaded_q || (hs && block_end_c)) begin
                num_bands_q <= cfg_eff;
            end
            if (hs) begin
                if (last_c) begin
                    sample_cnt <= '0;
                    band_index <= block_end_c ? '0 : band_index + BAND_WIDTH'(1);
                end else begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nthband_sequencer.sv
// Per-block band scheduler: steers band 0 samples to the first-band path, bands 1..N-1
// to the nth-band predictor, and releases one params beat ahead of each nth band.
module nthband_sequencer
    import lcplc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ALPHA_WIDTH    = DEF_ALPHA_WIDTH,
    parameter int unsigned BLOCK_SIZE_LOG = DEF_BLOCK_SIZE_LOG,
    parameter int unsigned BAND_WIDTH     = DEF_BAND_WIDTH
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [BAND_WIDTH-1:0]                              cfg_num_bands,
    input  logic                                               xhat_valid,
    output logic                                               xhat_ready,
    input  logic [DATA_WIDTH-1:0]                              xhat_data,
    output logic                                               first_valid,
    input  logic                                               first_ready,
    output logic [DATA_WIDTH-1:0]                              first_data,
    output logic                                               first_last,
    output logic                                               nth_valid,
    input  logic                                               nth_ready,
    output logic [DATA_WIDTH-1:0]                              nth_data,
    output logic                                               nth_last,
    input  logic                                               params_in_valid,
    output logic                                               params_in_ready,
    input  logic [params_width(ALPHA_WIDTH, DATA_WIDTH)-1:0]   params_in_data,
    output logic                                               params_out_valid,
    input  logic                                               params_out_ready,
    output logic [params_width(ALPHA_WIDTH, DATA_WIDTH)-1:0]   params_out_data,
    output logic [BAND_WIDTH-1:0]                              band_index,
    output logic                                               block_done
);

    seq_state_e state, state_nxt;
    logic       xhat_hs;
    logic       last_c;
    logic       block_end_c;

    // Data buses are pure pass-through; only the handshakes are steered.
    assign first_data      = xhat_data;
    assign nth_data        = xhat_data;
    assign params_out_data = params_in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        xhat_ready       = 1'b0;
        first_valid      = 1'b0;
        first_last       = 1'b0;
        nth_valid        = 1'b0;
        nth_last         = 1'b0;
        params_in_ready  = 1'b0;
        params_out_valid = 1'b0;
        xhat_hs          = 1'b0;
        // All handshakes are held off while reset is asserted.
        if (rst) begin
            case (state)
                ST_FIRST: begin
                    first_valid = xhat_valid;
                    first_last  = xhat_valid && last_c;
                    xhat_ready  = first_ready;
                    xhat_hs     = xhat_valid && first_ready;
                    if (xhat_hs && last_c && !block_end_c) begin
                        state_nxt = ST_PARAM;
                    end
                end
                ST_PARAM: begin
                    params_out_valid = params_in_valid;
                    params_in_ready  = params_out_ready;
                    if (params_in_valid && params_out_ready) begin
                        state_nxt = ST_NTH;
                    end
                end
                ST_NTH: begin
                    nth_valid  = xhat_valid;
                    nth_last   = xhat_valid && last_c;
                    xhat_ready = nth_ready;
                    xhat_hs    = xhat_valid && nth_ready;
                    if (xhat_hs && last_c) begin
                        state_nxt = block_end_c ? ST_FIRST : ST_PARAM;
                    end
                end
                default: state_nxt = ST_FIRST;
            endcase
        end
    end

    band_block_counter #(
        .BLOCK_SIZE_LOG (BLOCK_SIZE_LOG),
        .BAND_WIDTH     (BAND_WIDTH)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .hs            (xhat_hs),
        .cfg_num_bands (cfg_num_bands),
        .last_c        (last_c),
        .block_end_c   (block_end_c),
        .band_index    (band_index),
        .block_done    (block_done)
    );

endmodule
